// File: rtl/my_dmux_stream_if.sv
// Stream demux bus: one producer-side input port and CHANNELS consumer-side output slots.
// The slave modport is the demux view; the master modport is the producer/consumer view.
interface my_dmux_stream_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS);

  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic                      err_sel;

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_sel
  );

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_sel
  );
endinterface

// File: rtl/my_dmux_stream.sv
// 1-to-CHANNELS valid/ready stream demultiplexer with one registered slot per channel,
// optional all-or-nothing broadcast, and a drop-with-error path for out-of-range selects.
module my_dmux_stream #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic            clk,
  input  logic            reset,
  my_dmux_stream_if.slave bus
);

  logic [CHANNELS-1:0]       valid_q, valid_d;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic                      err_q, err_d;

  logic [CHANNELS-1:0] free_c;
  logic [CHANNELS-1:0] sel_hot_c;
  logic [CHANNELS-1:0] load_c;
  logic                sel_ok_c;
  logic                in_ready_c;
  logic                accept_c;

  // Slot availability and select decode; sel_hot_c is all-zero for an out-of-range select.
  always_comb begin
    free_c    = ~valid_q | bus.out_ready;
    sel_hot_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (32'(bus.in_sel) == i) sel_hot_c[i] = 1'b1;
    end
    sel_ok_c = |sel_hot_c;
  end

  // Acceptance: broadcast needs every slot free; out-of-range words are always swallowed.
  always_comb begin
    in_ready_c = 1'b0;
    if (reset) begin
      in_ready_c = 1'b0;
    end else if (bus.in_bcast) begin
      in_ready_c = &free_c;
    end else if (sel_ok_c) begin
      in_ready_c = |(free_c & sel_hot_c);
    end else begin
      in_ready_c = 1'b1;
    end
    accept_c = bus.in_valid && in_ready_c;
  end

  // Next slot state: drain clears, load sets and overwrites data; drain+load keeps valid high.
  always_comb begin
    load_c  = '0;
    err_d   = 1'b0;
    data_d  = data_q;
    if (accept_c) begin
      if (bus.in_bcast) begin
        load_c = '1;
      end else if (sel_ok_c) begin
        load_c = sel_hot_c;
      end else begin
        err_d = 1'b1;
      end
    end
    valid_d = (valid_q & ~bus.out_ready) | load_c;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (load_c[i]) data_d[i*WIDTH +: WIDTH] = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.err_sel   = err_q;

endmodule

// File: tb/tb_my_dmux_stream.sv
// Directed bench for my_dmux_stream: a 4-channel instance driven from a vector table
// plus a 3-channel instance for the out-of-range select path.
module tb_my_dmux_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  my_dmux_stream_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
  my_dmux_stream_if #(.WIDTH(8), .CHANNELS(3)) bus_b ();

  my_dmux_stream #(.WIDTH(8), .CHANNELS(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  my_dmux_stream #(.WIDTH(8), .CHANNELS(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        bcast;
    logic        valid;
    logic [7:0]  data;
    logic [3:0]  rdy;
    logic        exp_in_ready;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    // routing, all consumers ready
    vecs[0]  = '{2'd0, 1'b0, 1'b1, 8'hA0, 4'b1111, 1'b1, 4'b0001, 32'h000000A0, 1'b0};
    vecs[1]  = '{2'd1, 1'b0, 1'b1, 8'hA1, 4'b1111, 1'b1, 4'b0010, 32'h0000A1A0, 1'b0};
    vecs[2]  = '{2'd2, 1'b0, 1'b1, 8'hA2, 4'b1111, 1'b1, 4'b0100, 32'h00A2A1A0, 1'b0};
    vecs[3]  = '{2'd3, 1'b0, 1'b1, 8'hA3, 4'b1111, 1'b1, 4'b1000, 32'hA3A2A1A0, 1'b0};
    vecs[4]  = '{2'd3, 1'b0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'hA3A2A1A0, 1'b0};
    // backpressure on channel 2, channel 1 keeps flowing
    vecs[5]  = '{2'd2, 1'b0, 1'b1, 8'h11, 4'b1011, 1'b1, 4'b0100, 32'hA311A1A0, 1'b0};
    vecs[6]  = '{2'd2, 1'b0, 1'b1, 8'h22, 4'b1011, 1'b0, 4'b0100, 32'hA311A1A0, 1'b0};
    vecs[7]  = '{2'd1, 1'b0, 1'b1, 8'h33, 4'b1011, 1'b1, 4'b0110, 32'hA31133A0, 1'b0};
    vecs[8]  = '{2'd2, 1'b0, 1'b1, 8'h22, 4'b1111, 1'b1, 4'b0100, 32'hA32233A0, 1'b0};
    // broadcast blocked by a stalled full slot 3, then released
    vecs[9]  = '{2'd3, 1'b0, 1'b1, 8'h44, 4'b0111, 1'b1, 4'b1000, 32'h442233A0, 1'b0};
    vecs[10] = '{2'd0, 1'b1, 1'b1, 8'h5C, 4'b0111, 1'b0, 4'b1000, 32'h442233A0, 1'b0};
    vecs[11] = '{2'd0, 1'b1, 1'b1, 8'h5C, 4'b1111, 1'b1, 4'b1111, 32'h5C5C5C5C, 1'b0};
    // hold with no consumers, then partial drain keeping data
    vecs[12] = '{2'd0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b1111, 32'h5C5C5C5C, 1'b0};
    vecs[13] = '{2'd0, 1'b0, 1'b0, 8'h00, 4'b1010, 1'b0, 4'b0101, 32'h5C5C5C5C, 1'b0};

    reset              = 1'b1;
    bus_a.in_valid     = 1'b1;
    bus_a.in_sel       = 2'd0;
    bus_a.in_data      = 8'h77;
    bus_a.in_bcast     = 1'b0;
    bus_a.out_ready    = 4'b1111;
    bus_b.in_valid     = 1'b0;
    bus_b.in_sel       = 2'd0;
    bus_b.in_data      = 8'h00;
    bus_b.in_bcast     = 1'b0;
    bus_b.out_ready    = 3'b000;

    // reset held for two edges with a word offered
    #1;
    check("reset in_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    tick();
    check("reset out_valid", 32'(bus_a.out_valid), 32'd0);
    check("reset out_data", bus_a.out_data, 32'd0);
    check("reset err_sel", 32'(bus_a.err_sel), 32'd0);
    check("reset in_ready held", 32'(bus_a.in_ready), 32'd0);
    check("reset b out_valid", 32'(bus_b.out_valid), 32'd0);
    reset          = 1'b0;
    bus_a.in_valid = 1'b0;
    #1;
    check("release in_ready", 32'(bus_a.in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      bus_a.in_sel    = vecs[i].sel;
      bus_a.in_bcast  = vecs[i].bcast;
      bus_a.in_valid  = vecs[i].valid;
      bus_a.in_data   = vecs[i].data;
      bus_a.out_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(bus_a.in_ready), 32'(vecs[i].exp_in_ready));
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(bus_a.out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d out_data", i), bus_a.out_data, vecs[i].exp_data);
      check($sformatf("vec%0d err_sel", i), 32'(bus_a.err_sel), 32'(vecs[i].exp_err));
    end

    // out-of-range select on the 3-channel instance, with slot 0 held full
    bus_b.in_sel   = 2'd0;
    bus_b.in_data  = 8'h12;
    bus_b.in_valid = 1'b1;
    #1;
    check("oor pre in_ready", 32'(bus_b.in_ready), 32'd1);
    tick();
    check("oor pre out_valid", 32'(bus_b.out_valid), 32'd1);
    check("oor pre out_data", 32'(bus_b.out_data), 32'h000012);
    bus_b.in_sel  = 2'd3;
    bus_b.in_data = 8'hFF;
    #1;
    check("oor in_ready", 32'(bus_b.in_ready), 32'd1);
    tick();
    check("oor err_sel", 32'(bus_b.err_sel), 32'd1);
    check("oor out_valid", 32'(bus_b.out_valid), 32'd1);
    check("oor out_data", 32'(bus_b.out_data), 32'h000012);
    bus_b.in_valid = 1'b0;
    tick();
    check("oor err_sel pulse end", 32'(bus_b.err_sel), 32'd0);
    check("oor out_valid after", 32'(bus_b.out_valid), 32'd1);

    // reset with stalled full slots discards them
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 4'b0000;
    tick();
    check("midrst stalled valid", 32'(bus_a.out_valid), 32'h5);
    reset = 1'b1;
    tick();
    check("midrst out_valid", 32'(bus_a.out_valid), 32'd0);
    check("midrst out_data", bus_a.out_data, 32'd0);
    reset           = 1'b0;
    bus_a.out_ready = 4'b1111;
    tick();
    check("midrst no delivery", 32'(bus_a.out_valid), 32'd0);
    check("midrst err_sel", 32'(bus_a.err_sel), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
